threshold_rom_arbiter: RTL and testbench

- Shares one stage-threshold ROM read port (a dti address channel in, a dti data channel back) between two requesters: the stage sequencer and the debug/readback path.
- Arbitrates address requests round-robin and tracks outstanding reads in an in-order tag FIFO.
- Routes each returned data word back to the requester that issued it.
- Sits between the requesters and the threshold memory wrapper; the memory wrapper is not modified.

---
 rtl/threshold_rom_arbiter_if.sv | 13 +
 rtl/threshold_rom_arbiter.sv | 170 +++++++++++++++++
 tb/tb_threshold_rom_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/threshold_rom_arbiter_if.sv
// dti valid/ready transfer channel shared by the ROM read port and its requesters.
// A transfer occurs on a rising edge where valid && ready; the producer holds
// valid and data stable until then.
interface dti #(
  parameter int unsigned W = 16
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport producer (output valid, output data, input ready);
  modport consumer (input valid, input data, output ready);
endinterface

// File: rtl/threshold_rom_arbiter.sv
// threshold_rom_arbiter: shares one stage-threshold ROM read port between the
// stage sequencer (requester 0) and the debug/readback path (requester 1).
// Address requests are granted round-robin; an in-order tag FIFO remembers who
// issued each outstanding read so returned words are routed back correctly.
module threshold_rom_arbiter #(
  parameter int unsigned W_ADDR          = 16,
  parameter int unsigned W_DATA          = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic  clk,
  input  logic  rst,
  dti.consumer  req0_addr_if,
  dti.consumer  req1_addr_if,
  dti.producer  req0_data_if,
  dti.producer  req1_data_if,
  dti.producer  mem_addr_if,
  dti.consumer  mem_data_if,
  output logic  err_o
);

  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic {
    ARB_OPEN,
    ARB_LOCKED
  } arb_state_t;

  arb_state_t                 state;
  logic                       lock_idx;
  logic                       prio;
  logic [MAX_OUTSTANDING-1:0] tag_mem;
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [CNT_W-1:0]           count;
  logic                       err_q;

  logic                       gnt_any;
  logic                       gnt_idx;
  logic                       gnt_valid;
  logic [W_ADDR-1:0]          gnt_addr;
  logic                       addr_fire;

  logic                       have_tag;
  logic                       head_tag;
  logic                       ret0_valid;
  logic                       ret1_valid;
  logic                       mem_data_ready;
  logic [W_DATA-1:0]          ret_data;
  logic                       data_fire;
  logic                       pop;
  logic                       orphan;

  // Grant selection: a locked grant is held until its address transfers;
  // otherwise round-robin among valid requesters while tags remain. Gated by
  // reset so no handshake is offered while rst is low.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = 1'b0;
    if (rst) begin
      if (state == ARB_LOCKED) begin
        gnt_any = 1'b1;
        gnt_idx = lock_idx;
      end else if (count < CNT_FULL) begin
        if (req0_addr_if.valid && req1_addr_if.valid) begin
          gnt_any = 1'b1;
          gnt_idx = prio;
        end else if (req0_addr_if.valid) begin
          gnt_any = 1'b1;
          gnt_idx = 1'b0;
        end else if (req1_addr_if.valid) begin
          gnt_any = 1'b1;
          gnt_idx = 1'b1;
        end
      end
    end
  end

  assign gnt_valid = gnt_any && (gnt_idx ? req1_addr_if.valid : req0_addr_if.valid);
  assign gnt_addr  = gnt_idx ? req1_addr_if.data : req0_addr_if.data;
  assign addr_fire = gnt_valid && mem_addr_if.ready;

  assign mem_addr_if.valid  = gnt_valid;
  assign mem_addr_if.data   = gnt_addr;
  assign req0_addr_if.ready = gnt_any && !gnt_idx && mem_addr_if.ready;
  assign req1_addr_if.ready = gnt_any &&  gnt_idx && mem_addr_if.ready;

  assign have_tag = (count != '0);
  assign head_tag = tag_mem[rd_ptr];
  assign ret_data = mem_data_if.data;

  // Return routing: the head tag selects the destination; with no tag
  // outstanding the word is accepted and dropped.
  always_comb begin
    ret0_valid     = 1'b0;
    ret1_valid     = 1'b0;
    mem_data_ready = 1'b1;
    if (have_tag) begin
      if (head_tag) begin
        ret1_valid     = mem_data_if.valid;
        mem_data_ready = req1_data_if.ready;
      end else begin
        ret0_valid     = mem_data_if.valid;
        mem_data_ready = req0_data_if.ready;
      end
    end
  end

  assign data_fire = mem_data_if.valid && mem_data_ready;
  assign pop       = data_fire && have_tag;
  assign orphan    = data_fire && !have_tag;

  assign req0_data_if.valid = ret0_valid;
  assign req1_data_if.valid = ret1_valid;
  assign req0_data_if.data  = ret_data;
  assign req1_data_if.data  = ret_data;
  assign mem_data_if.ready  = mem_data_ready;
  assign err_o              = err_q;

  // Lock FSM, round-robin pointer, tag FIFO and sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ARB_OPEN;
      lock_idx <= 1'b0;
      prio     <= 1'b0;
      tag_mem  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ARB_OPEN: begin
          if (gnt_valid && !mem_addr_if.ready) begin
            state    <= ARB_LOCKED;
            lock_idx <= gnt_idx;
          end
        end
        ARB_LOCKED: begin
          if (addr_fire) begin
            state <= ARB_OPEN;
          end
        end
        default: state <= ARB_OPEN;
      endcase

      if (addr_fire) begin
        tag_mem[wr_ptr] <= gnt_idx;
        wr_ptr          <= wr_ptr + 1'b1;
        prio            <= ~gnt_idx;
      end

      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      case ({addr_fire, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (orphan) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_threshold_rom_arbiter.sv
// Scoreboard bench for threshold_rom_arbiter: stimulus pushes hand-computed
// expected addresses/data into queues, a negedge monitor pops and compares.
// The ROM model returns (address + 0x1000) for each accepted address.
module tb_threshold_rom_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic mem_rdy;
  logic r0_rdy;
  logic r1_rdy;
  logic err;

  always #5 clk = ~clk;

  dti #(.W(16)) r0a ();
  dti #(.W(16)) r1a ();
  dti #(.W(16)) r0d ();
  dti #(.W(16)) r1d ();
  dti #(.W(16)) maddr ();
  dti #(.W(16)) mdat ();

  assign maddr.ready = mem_rdy;
  assign r0d.ready   = r0_rdy;
  assign r1d.ready   = r1_rdy;

  threshold_rom_arbiter #(
    .W_ADDR          (16),
    .W_DATA          (16),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_addr_if (r0a),
    .req1_addr_if (r1a),
    .req0_data_if (r0d),
    .req1_data_if (r1d),
    .mem_addr_if  (maddr),
    .mem_data_if  (mdat),
    .err_o        (err)
  );

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] rom_q[$];
  logic [15:0] exp_addr[$];
  logic [15:0] exp0[$];
  logic [15:0] exp1[$];

  int passed = 0;
  int total  = 0;
  int addr_xfers = 0;
  int credits = 1000;
  bit a0_fire = 1'b0;
  bit a1_fire = 1'b0;
  bit md_fire = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h, required %h", name, got, want);
  endtask

  task automatic unexpected(input string name, input logic [31:0] got);
    total++;
    $display("FAIL %s: got %h, required nothing (queue empty)", name, got);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake that will complete on the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      if (r0a.valid && r0a.ready) a0_fire = 1'b1;
      if (r1a.valid && r1a.ready) a1_fire = 1'b1;
      if (maddr.valid && maddr.ready) begin
        addr_xfers++;
        if (exp_addr.size() == 0) unexpected("mem_addr", maddr.data);
        else check("mem_addr", maddr.data, exp_addr.pop_front());
        rom_q.push_back(maddr.data + 16'h1000);
      end
      if (mdat.valid && mdat.ready) md_fire = 1'b1;
      if (r0d.valid && r1d.valid) unexpected("both_data_valid", 1);
      if (r0d.valid && r0d.ready) begin
        if (exp0.size() == 0) unexpected("req0_data", r0d.data);
        else check("req0_data", r0d.data, exp0.pop_front());
      end
      if (r1d.valid && r1d.ready) begin
        if (exp1.size() == 0) unexpected("req1_data", r1d.data);
        else check("req1_data", r1d.data, exp1.pop_front());
      end
    end
  end

  // Requester 0 address driver.
  initial begin
    r0a.valid = 1'b0;
    r0a.data  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (a0_fire) begin
        if (q0.size() > 0) q0.delete(0);
        a0_fire = 1'b0;
      end
      if (q0.size() > 0) begin
        r0a.valid = 1'b1;
        r0a.data  = q0[0];
      end else r0a.valid = 1'b0;
    end
  end

  // Requester 1 address driver.
  initial begin
    r1a.valid = 1'b0;
    r1a.data  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (a1_fire) begin
        if (q1.size() > 0) q1.delete(0);
        a1_fire = 1'b0;
      end
      if (q1.size() > 0) begin
        r1a.valid = 1'b1;
        r1a.data  = q1[0];
      end else r1a.valid = 1'b0;
    end
  end

  // ROM responder: presents queued words while credits remain.
  initial begin
    mdat.valid = 1'b0;
    mdat.data  = '0;
    forever begin
      @(posedge clk);
      #3;
      if (md_fire) begin
        if (rom_q.size() > 0) rom_q.delete(0);
        if (credits > 0) credits--;
        md_fire    = 1'b0;
        mdat.valid = 1'b0;
      end
      if (!mdat.valid && rom_q.size() > 0 && credits > 0) begin
        mdat.valid = 1'b1;
        mdat.data  = rom_q[0];
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    q0.delete();
    q1.delete();
    rom_q.delete();
    exp_addr.delete();
    exp0.delete();
    exp1.delete();
    a0_fire    = 1'b0;
    a1_fire    = 1'b0;
    md_fire    = 1'b0;
    mdat.valid = 1'b0;
    credits    = 1000;
    mem_rdy    = 1'b1;
    r0_rdy     = 1'b1;
    r1_rdy     = 1'b1;
    addr_xfers = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int left;
    for (int i = 0; i < 300; i++) begin
      left = q0.size() + q1.size() + rom_q.size() + exp_addr.size() + exp0.size() + exp1.size();
      if (left == 0) break;
      tick();
    end
    left = q0.size() + q1.size() + rom_q.size() + exp_addr.size() + exp0.size() + exp1.size();
    check(name, left, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst     = 1'b0;
    mem_rdy = 1'b1;
    r0_rdy  = 1'b1;
    r1_rdy  = 1'b1;
    #1;
    check("rst_mem_addr_valid", maddr.valid, 0);
    check("rst_req0_data_valid", r0d.valid, 0);
    check("rst_req1_data_valid", r1d.valid, 0);
    check("rst_err", err, 0);
    do_reset();

    // Single requester, back-to-back addresses 0,1,2.
    for (int i = 0; i < 3; i++) begin
      q0.push_back(16'(i));
      exp_addr.push_back(16'(i));
    end
    exp0.push_back(16'h1000);
    exp0.push_back(16'h1001);
    exp0.push_back(16'h1002);
    wait_idle("t1_drain");
    check("t1_err", err, 0);

    // Both requesters continuously valid: grants alternate starting with req0.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(16'h0010);
      q1.push_back(16'h0020);
      exp_addr.push_back(16'h0010);
      exp_addr.push_back(16'h0020);
      exp0.push_back(16'h1010);
      exp1.push_back(16'h1020);
    end
    wait_idle("t2_drain");

    // Address back-pressure: lock holds req0's address, req1 follows.
    do_reset();
    mem_rdy = 1'b0;
    tick();
    q0.push_back(16'h0010);
    exp_addr.push_back(16'h0010);
    exp_addr.push_back(16'h0020);
    exp0.push_back(16'h1010);
    exp1.push_back(16'h1020);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t3_stall_valid", maddr.valid, 1);
      check("t3_stall_addr", maddr.data, 16'h0010);
      check("t3_stall_r1_ready", r1a.ready, 0);
      tick();
      if (c == 0) q1.push_back(16'h0020);
    end
    mem_rdy = 1'b1;
    @(negedge clk);
    check("t3_release_addr", maddr.data, 16'h0010);
    @(negedge clk);
    check("t3_next_valid", maddr.valid, 1);
    check("t3_next_addr", maddr.data, 16'h0020);
    check("t3_next_r1_ready", r1a.ready, 1);
    wait_idle("t3_drain");

    // Tag FIFO full: four transfers, then a grant the cycle after a pop.
    do_reset();
    credits = 0;
    for (int i = 0; i < 6; i++) begin
      q1.push_back(16'h0030 + 16'(i));
      exp_addr.push_back(16'h0030 + 16'(i));
      exp1.push_back(16'h1030 + 16'(i));
    end
    repeat (10) tick();
    check("t4_xfers_at_full", addr_xfers, 4);
    @(negedge clk);
    check("t4_full_no_valid", maddr.valid, 0);
    tick();
    credits = 1;
    @(negedge clk);
    check("t4_pop_cycle_ret_valid", mdat.valid, 1);
    check("t4_pop_cycle_no_grant", maddr.valid, 0);
    tick();
    @(negedge clk);
    check("t4_after_pop_valid", maddr.valid, 1);
    check("t4_after_pop_addr", maddr.data, 16'h0034);
    credits = 1000;
    wait_idle("t4_drain");
    check("t4_total_xfers", addr_xfers, 6);

    // Return back-pressure from req0 stalls req1's return behind it.
    do_reset();
    credits = 0;
    r0_rdy  = 1'b0;
    q0.push_back(16'h0040);
    q1.push_back(16'h0050);
    exp_addr.push_back(16'h0040);
    exp_addr.push_back(16'h0050);
    exp0.push_back(16'h1040);
    exp1.push_back(16'h1050);
    repeat (5) tick();
    credits = 1000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t5_mem_data_ready", mdat.ready, 0);
      check("t5_r0_valid", r0d.valid, 1);
      check("t5_r1_valid", r1d.valid, 0);
      tick();
    end
    r0_rdy = 1'b1;
    wait_idle("t5_drain");

    // Orphan return: dropped, sticky error; then asynchronous reset mid-stream.
    do_reset();
    rom_q.push_back(16'hDEAD);
    @(negedge clk);
    check("t6_orphan_valid", mdat.valid, 1);
    check("t6_orphan_ready", mdat.ready, 1);
    check("t6_orphan_r0", r0d.valid, 0);
    check("t6_orphan_r1", r1d.valid, 0);
    check("t6_err_before", err, 0);
    @(negedge clk);
    check("t6_err_set", err, 1);
    repeat (3) tick();
    check("t6_err_sticky", err, 1);
    for (int i = 0; i < 3; i++) begin
      q0.push_back(16'h0060 + 16'(i));
      exp_addr.push_back(16'h0060 + 16'(i));
      exp0.push_back(16'h1060 + 16'(i));
    end
    tick();
    tick();
    #3;
    rst = 1'b0;
    #1;
    check("t6_async_mem_addr_valid", maddr.valid, 0);
    check("t6_async_r0_addr_ready", r0a.ready, 0);
    check("t6_async_r0_data_valid", r0d.valid, 0);
    check("t6_async_r1_data_valid", r1d.valid, 0);
    check("t6_async_err", err, 0);
    do_reset();
    q0.push_back(16'h0070);
    exp_addr.push_back(16'h0070);
    exp0.push_back(16'h1070);
    wait_idle("t6_post_reset_drain");
    check("t6_post_reset_err", err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
